// File: rtl/imem_responder.sv
// Instruction-memory responder: store read at accept, LATENCY-stage pipeline, then an in-order response FIFO.
// resp_valid rises LATENCY cycles after accept; req_ready is credit-gated so the FIFO can never overflow under stall.

// Generic synchronous FIFO; head is presented combinationally from storage and forced to zero when empty.
module imem_responder_fifo #(
  parameter int  W     = 8,
  parameter int  DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_vld,
  input  logic [W-1:0]     push_dat,
  output logic             pop_vld,
  input  logic             pop_rdy,
  output logic [W-1:0]     pop_dat,
  output logic [CNT_W-1:0] count
);
  logic [W-1:0]     store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop_vld = (count != '0);
  assign pop     = pop_vld && pop_rdy;
  assign pop_dat = pop_vld ? store[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push_vld) store[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)      rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push_vld) - CNT_W'(pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push_vld && (count == CNT_W'(DEPTH))));
endmodule

module imem_responder #(
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = 10,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [63:0]       req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_instr,
  output logic [63:0]       resp_addr,
  output logic              resp_fault,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_data,
  output logic              busy
);
  localparam int             CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] CREDITS = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [31:0]    NOP     = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] addr;
    logic        fault;
  } resp_t;

  typedef struct packed {
    logic  vld;
    resp_t ent;
  } stage_t;

  logic [31:0]       mem [DEPTH];
  stage_t            stg [LATENCY];
  resp_t             fetch;
  resp_t             head;
  logic              accept;
  logic              req_fault;
  logic [ADDR_W-1:0] req_idx;
  logic [CNT_W-1:0]  in_flight;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    outstanding;

  assign req_idx     = req_addr[ADDR_W+1:2];
  assign req_fault   = (req_addr[1:0] != 2'b00) || (req_addr[63:ADDR_W+2] != '0);
  assign outstanding = {1'b0, in_flight} + {1'b0, fifo_count};
  // Credit counts only registered state, so a same-cycle pop frees a slot one cycle later.
  assign req_ready   = reset && (outstanding < CREDITS);
  assign accept      = req_valid && req_ready;

  // Not reset: program contents must survive a reset pulse.
  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr] <= prog_data;
  end

  // Sampled before this edge's write lands, giving read-before-write on a collision.
  always_comb begin
    fetch       = '0;
    fetch.instr = req_fault ? NOP : mem[req_idx];
    fetch.addr  = req_addr;
    fetch.fault = req_fault;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LATENCY; i++) stg[i] <= '0;
      in_flight <= '0;
    end else begin
      stg[0].vld <= accept;
      stg[0].ent <= fetch;
      for (int i = 1; i < LATENCY; i++) stg[i] <= stg[i-1];
      in_flight <= in_flight + CNT_W'(accept) - CNT_W'(stg[LATENCY-1].vld);
    end
  end

  imem_responder_fifo #(
    .W     ($bits(resp_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_resp_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (stg[LATENCY-1].vld),
    .push_dat (stg[LATENCY-1].ent),
    .pop_vld  (resp_valid),
    .pop_rdy  (resp_ready),
    .pop_dat  (head),
    .count    (fifo_count)
  );

  assign resp_instr = head.instr;
  assign resp_addr  = head.addr;
  assign resp_fault = head.fault;
  assign busy       = (in_flight != '0) || (fifo_count != '0);
endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed vectors on the default build, randomized scoreboard run on a LATENCY=1 build.
module tb_imem_responder;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default build (LATENCY=2, FIFO_DEPTH=4)
  logic        reset, req_valid, req_ready, resp_valid, resp_ready, resp_fault, prog_we, busy;
  logic [63:0] req_addr, resp_addr;
  logic [31:0] resp_instr, prog_data;
  logic [9:0]  prog_addr;

  // LATENCY=1, FIFO_DEPTH=2 build
  logic        r_reset, r_req_valid, r_req_ready, r_resp_valid, r_resp_ready, r_resp_fault, r_prog_we, r_busy;
  logic [63:0] r_req_addr, r_resp_addr;
  logic [31:0] r_resp_instr, r_prog_data;
  logic [9:0]  r_prog_addr;

  imem_responder dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_instr(resp_instr), .resp_addr(resp_addr),
    .resp_fault(resp_fault), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .busy(busy)
  );

  imem_responder #(.DEPTH(1024), .ADDR_W(10), .LATENCY(1), .FIFO_DEPTH(2)) dut1 (
    .clk(clk), .reset(r_reset), .req_valid(r_req_valid), .req_ready(r_req_ready), .req_addr(r_req_addr),
    .resp_valid(r_resp_valid), .resp_ready(r_resp_ready), .resp_instr(r_resp_instr), .resp_addr(r_resp_addr),
    .resp_fault(r_resp_fault), .prog_we(r_prog_we), .prog_addr(r_prog_addr), .prog_data(r_prog_data), .busy(r_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  typedef struct {
    logic [63:0] addr;
    logic [31:0] instr;
    logic        fault;
  } vec_t;

  // One isolated request on the default build: response must appear exactly 2 cycles after accept.
  task automatic do_req(input vec_t v, input string tag);
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = v.addr;
    #1 check({tag, "_ready"}, req_ready, 1);
    tick();
    req_valid = 1'b0;
    prog_we   = 1'b0;
    check({tag, "_early0"}, resp_valid, 0);
    tick();
    check({tag, "_early1"}, resp_valid, 0);
    tick();
    check({tag, "_valid"}, resp_valid, 1);
    check({tag, "_instr"}, resp_instr, v.instr);
    check({tag, "_addr"}, resp_addr, v.addr);
    check({tag, "_fault"}, resp_fault, v.fault);
    tick();
    check({tag, "_idle"}, busy, 0);
  endtask

  typedef struct {
    logic [63:0] addr;
    logic [31:0] instr;
    logic        fault;
    int          c;
  } item_t;

  vec_t        vecs [9];
  vec_t        v;
  item_t       q [$];
  item_t       it;
  logic [31:0] shadow [1024];
  logic [63:0] a;
  int          acc, idx, kind, cyc;
  logic        exp_v, exp_ready, exp_valid, do_acc, do_pop;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    r_reset = 1'b0; r_req_valid = 1'b0; r_req_addr = '0; r_resp_ready = 1'b0;
    r_prog_we = 1'b0; r_prog_addr = '0; r_prog_data = '0;

    vecs[0] = '{64'h0,            32'h00500093, 1'b0};
    vecs[1] = '{64'h4,            32'h00A00113, 1'b0};
    vecs[2] = '{64'h8,            32'h002081B3, 1'b0};
    vecs[3] = '{64'hC,            32'h00000013, 1'b0};
    vecs[4] = '{64'h6,            NOP,          1'b1};
    vecs[5] = '{64'h1000,         NOP,          1'b1};
    vecs[6] = '{64'h3,            NOP,          1'b1};
    vecs[7] = '{64'hFFC,          32'hCAFEF00D, 1'b0};
    vecs[8] = '{64'h100_0000_0000, NOP,         1'b1};

    @(negedge clk);
    // Writes are legal while reset is held
    load(10'd0, 32'h00500093);
    load(10'd1, 32'h00A00113);
    load(10'd2, 32'h002081B3);
    load(10'd3, 32'h00000013);
    load(10'd5, 32'h11111111);
    load(10'd1023, 32'hCAFEF00D);

    check("rst_ready", req_ready, 0);
    check("rst_valid", resp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_instr", resp_instr, 0);
    check("rst_addr", resp_addr, 0);
    check("rst_fault", resp_fault, 0);
    reset = 1'b1;
    #1 check("rel_ready", req_ready, 1);
    @(negedge clk);

    // Back-to-back fetch of four words with the consumer always ready
    resp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k < 4) begin
        req_valid = 1'b1;
        req_addr  = 64'(4 * k);
        #1 check("bb_ready", req_ready, 1);
      end else begin
        req_valid = 1'b0;
      end
      tick();
      exp_v = (k >= 2) && (k <= 5);
      check("bb_valid", resp_valid, exp_v);
      if (exp_v) begin
        check("bb_instr", resp_instr, vecs[k-2].instr);
        check("bb_addr", resp_addr, 64'(4 * (k - 2)));
        check("bb_fault", resp_fault, 0);
      end
    end
    check("bb_busy", busy, 0);

    for (int i = 0; i < 9; i++) do_req(vecs[i], $sformatf("vec%0d", i));

    // Stalled consumer: credit must cap accepts at FIFO_DEPTH
    resp_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      req_valid = 1'b1;
      req_addr  = 64'(4 * (k % 4));
      #1 if (req_ready) acc++;
      if (k >= 4) check("bp_stable", resp_addr, 64'h0);
      tick();
    end
    req_valid = 1'b0;
    check("bp_accepts", acc, 4);
    check("bp_ready", req_ready, 0);
    check("bp_hold_valid", resp_valid, 1);
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", resp_valid, 1);
      check("drain_addr", resp_addr, 64'(4 * i));
      check("drain_instr", resp_instr, vecs[i].instr);
      tick();
      if (i == 0) check("drain_credit", req_ready, 1);
    end
    check("drain_empty", resp_valid, 0);
    check("drain_busy", busy, 0);

    // Write and read of the same word on one edge
    prog_we = 1'b1; prog_addr = 10'd5; prog_data = 32'hDEADBEEF;
    v = '{64'h14, 32'h11111111, 1'b0};
    do_req(v, "rbw_old");
    v = '{64'h14, 32'hDEADBEEF, 1'b0};
    do_req(v, "rbw_new");

    // Reset with requests in flight
    resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1;
      req_addr  = 64'(4 * k);
      tick();
    end
    req_valid = 1'b0;
    check("mid_busy_pre", busy, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_ready", req_ready, 0);
    check("mid_rst_valid", resp_valid, 0);
    check("mid_rst_busy", busy, 0);
    tick();
    reset = 1'b1;
    resp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("mid_no_resp", resp_valid, 0);
      check("mid_idle", busy, 0);
    end
    v = '{64'h0, 32'h00500093, 1'b0};
    do_req(v, "mid_mem0");
    v = '{64'h14, 32'hDEADBEEF, 1'b0};
    do_req(v, "mid_mem5");

    // Randomized run on the LATENCY=1, FIFO_DEPTH=2 build against a queue model
    for (int i = 0; i < 16; i++) begin
      r_prog_we   = 1'b1;
      r_prog_addr = 10'(i);
      r_prog_data = $urandom;
      shadow[i]   = r_prog_data;
      tick();
    end
    r_prog_we = 1'b0;
    check("r_rst_ready", r_req_ready, 0);
    r_reset = 1'b1;
    #1 check("r_rel_ready", r_req_ready, 1);
    @(negedge clk);
    cyc = 0;
    for (int n = 0; n < 1040; n++) begin
      // Outstanding = accepted but not yet consumed; the head shows once its latency has elapsed
      exp_ready = (q.size() < 2);
      exp_valid = (q.size() > 0) && (cyc >= q[0].c + 1);
      check("rnd_ready", r_req_ready, exp_ready);
      check("rnd_valid", r_resp_valid, exp_valid);
      check("rnd_busy", r_busy, q.size() > 0);
      if (exp_valid) begin
        check("rnd_instr", r_resp_instr, q[0].instr);
        check("rnd_addr", r_resp_addr, q[0].addr);
        check("rnd_fault", r_resp_fault, q[0].fault);
      end

      idx  = $urandom_range(0, 15);
      kind = $urandom_range(0, 9);
      a    = 64'(idx) << 2;
      if (kind == 7)      a = a | 64'($urandom_range(1, 3));
      else if (kind == 8) a = a | (64'($urandom_range(1, 255)) << 12);
      else if (kind == 9) a = a | 64'h8000_0000_0000_0000;
      r_req_addr   = a;
      r_req_valid  = (n < 1000) && ($urandom_range(0, 3) != 0);
      r_resp_ready = (n >= 1000) || ($urandom_range(0, 3) != 0);
      r_prog_we    = (n < 1000) && ($urandom_range(0, 4) == 0);
      r_prog_addr  = 10'($urandom_range(0, 15));
      r_prog_data  = $urandom;

      do_acc = r_req_valid && exp_ready;
      do_pop = exp_valid && r_resp_ready;
      it.addr  = a;
      it.fault = (a[1:0] != 2'b00) || (a[63:12] != '0);
      it.instr = it.fault ? NOP : shadow[a[11:2]];

      @(posedge clk);
      cyc++;
      if (do_pop) void'(q.pop_front());
      if (do_acc) begin
        it.c = cyc;
        q.push_back(it);
      end
      if (r_prog_we) shadow[r_prog_addr] = r_prog_data;
      @(negedge clk);
    end
    check("rnd_end_valid", r_resp_valid, 0);
    check("rnd_end_busy", r_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
